// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared control-path types and sizing for the multi-cycle MUL sequencer.
package cpu_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, ITER, FIN} mul_state_t;
    localparam int MUL_WIDTH = 16;
    localparam int MUL_CNT_W = $clog2(MUL_WIDTH + 1);
endpackage

// File: rtl/mul_sequencer.sv
// mul_sequencer: load / WIDTH add-shift steps / finish control for the H6 shift-add multiplier.
module mul_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH,
    parameter int CNT_W = MUL_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             hold,
    input  logic             q0,
    output logic             h6_load,
    output logic             h6_step,
    output logic             h6_add,
    output logic             MUL1,
    output logic             MUL2,
    output logic             MUL3,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] iter
);
    mul_state_t state, state_nx;
    logic [CNT_W-1:0] iter_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            iter  <= '0;
        end else begin
            state <= state_nx;
            iter  <= iter_nx;
        end
    end

    always_comb begin
        state_nx = state;
        iter_nx  = iter;
        if (abort) begin
            state_nx = IDLE;
            iter_nx  = '0;
        end else if (!hold) begin
            case (state)
                IDLE: state_nx = start ? LOAD : IDLE;
                LOAD: begin
                    state_nx = ITER;
                    iter_nx  = CNT_W'(WIDTH - 1);
                end
                ITER: begin
                    state_nx = (iter == '0) ? FIN : ITER;
                    iter_nx  = (iter == '0) ? iter : iter - 1'b1;
                end
                FIN: state_nx = IDLE;
                default: begin
                    state_nx = IDLE;
                    iter_nx  = '0;
                end
            endcase
        end
        // MUL3 fires once on the first non-held, non-aborted FIN cycle
        MUL1    = state == LOAD;
        MUL2    = state == ITER;
        MUL3    = (state == FIN) && !hold && !abort;
        done    = MUL3;
        busy    = state != IDLE;
        h6_load = MUL1 && !hold;
        h6_step = MUL2 && !hold;
        h6_add  = MUL2 && q0 && !hold;
    end
endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: directed vectors for mul_sequencer with a small H6 datapath and PSW Z model.
module tb_mul_sequencer;
    import cpu_ctrl_pkg::*;
    localparam int W  = 16;
    localparam int CW = 5;

    logic clk = 0, rst_n = 0, start = 0, abort = 0, hold = 0, q0;
    logic h6_load, h6_step, h6_add, MUL1, MUL2, MUL3, busy, done;
    logic [CW-1:0] iter;
    int n_cmp = 0, n_bad = 0;

    mul_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .hold(hold), .q0(q0),
        .h6_load(h6_load), .h6_step(h6_step), .h6_add(h6_add),
        .MUL1(MUL1), .MUL2(MUL2), .MUL3(MUL3), .busy(busy), .done(done), .iter(iter)
    );

    always #5 clk = ~clk;

    // H6 A/Q/M registers and PSW Z, driven by strobes captured mid-cycle
    logic [15:0] a_r = 0, q_r = 0, m_r = 0, mcand = 0, mplr = 0;
    logic z_r = 0, ld_s = 0, st_s = 0, ad_s = 0, m3_s = 0;
    logic [16:0] sum;
    assign q0  = q_r[0];
    assign sum = {1'b0, a_r} + (ad_s ? {1'b0, m_r} : 17'd0);

    always @(negedge clk) begin
        ld_s = h6_load;
        st_s = h6_step;
        ad_s = h6_add;
        m3_s = MUL3;
    end

    always @(posedge clk) begin
        if (ld_s) begin
            a_r <= 16'd0;
            q_r <= mplr;
            m_r <= mcand;
        end else if (st_s) begin
            {a_r, q_r} <= {sum, q_r[15:1]};
        end
        if (m3_s) z_r <= ({a_r, q_r} == 32'd0);
    end

    typedef struct {
        logic       s, h, a;
        logic [7:0] eo;
        logic [4:0] ei;
    } vec_t;
    vec_t tbl[20];

    function automatic logic [7:0] outs();
        return {h6_load, h6_step, h6_add, MUL1, MUL2, MUL3, done, busy};
    endfunction

    function automatic vec_t basic_row(int c, logic [15:0] mp);
        vec_t v;
        logic it;
        it   = (c >= 2) && (c <= 17);
        v.s  = (c == 0);
        v.h  = 1'b0;
        v.a  = 1'b0;
        v.eo = {c == 1, it, it && mp[(c >= 2) ? c - 2 : 0], c == 1, it, c == 18, c == 18,
                (c >= 1) && (c <= 18)};
        v.ei = it ? 5'(17 - c) : 5'd0;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic h, input logic a);
        @(posedge clk);
        #1;
        start = s;
        hold  = h;
        abort = a;
        @(negedge clk);
    endtask

    initial begin
        int nd, nm3, nst;
        #12;
        chk("reset_outs", 32'(outs()), 32'd0);
        chk("reset_iter", 32'(iter), 32'd0);
        @(posedge clk);
        #1 rst_n = 1;

        // basic run 7*5
        mcand = 16'd7;
        mplr  = 16'h0005;
        foreach (tbl[c]) tbl[c] = basic_row(c, mplr);
        for (int c = 0; c < 20; c++) begin
            drive(tbl[c].s, tbl[c].h, tbl[c].a);
            chk($sformatf("basic_outs c%0d", c), 32'(outs()), 32'(tbl[c].eo));
            chk($sformatf("basic_iter c%0d", c), 32'(iter), 32'(tbl[c].ei));
        end
        chk("basic_product", {a_r, q_r}, 32'h0000_0023);
        chk("basic_z", 32'(z_r), 32'd0);

        // zero result sets Z
        mcand = 16'd0;
        mplr  = 16'h1234;
        nd = 0;
        for (int c = 0; c < 20; c++) begin
            drive(c == 0, 1'b0, 1'b0);
            nd += int'(done);
            if (c == 18) chk("zero_done_c18", 32'(done), 32'd1);
        end
        chk("zero_done_count", 32'(nd), 32'd1);
        chk("zero_product", {a_r, q_r}, 32'd0);
        chk("zero_z", 32'(z_r), 32'd1);

        // hold 3 cycles mid-ITER and 2 cycles in FIN
        mcand = 16'd3;
        mplr  = 16'h00ff;
        nd = 0; nm3 = 0; nst = 0;
        for (int c = 0; c < 25; c++) begin
            drive(c == 0, (c >= 9 && c <= 11) || c == 21 || c == 22, 1'b0);
            nd += int'(done);
            nm3 += int'(MUL3);
            nst += int'(h6_step);
            if (c >= 9 && c <= 12) chk($sformatf("hold_iter c%0d", c), 32'(iter), 32'd8);
            if (c >= 9 && c <= 11) chk($sformatf("hold_step c%0d", c), {31'd0, h6_step}, 32'd0);
            if (c >= 9 && c <= 11) chk($sformatf("hold_mul2 c%0d", c), {31'd0, MUL2}, 32'd1);
            if (c == 12) chk("hold_step_resume", {31'd0, h6_step}, 32'd1);
            if (c == 21 || c == 22) chk($sformatf("hold_fin c%0d", c), {29'd0, MUL3, done, busy}, 32'd1);
            if (c == 23) chk("hold_done_c23", {30'd0, MUL3, done}, 32'd3);
        end
        chk("hold_done_count", 32'(nd), 32'd1);
        chk("hold_mul3_count", 32'(nm3), 32'd1);
        chk("hold_step_count", 32'(nst), 32'd16);
        chk("hold_product", {a_r, q_r}, 32'h0000_02fd);

        // abort at step 10, restart next cycle
        nd = 0;
        for (int c = 0; c < 13; c++) begin
            drive(c == 0, 1'b0, c == 12);
            nd += int'(done);
        end
        drive(1'b1, 1'b0, 1'b0);
        chk("abort_idle", {29'd0, busy, MUL2, done}, 32'd0);
        chk("abort_iter", 32'(iter), 32'd0);
        chk("abort_no_done", 32'(nd), 32'd0);
        drive(1'b0, 1'b0, 1'b0);
        chk("abort_restart_mul1", {31'd0, MUL1}, 32'd1);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        chk("abort_clean", {31'd0, busy}, 32'd0);

        // abort during FIN suppresses MUL3/done
        for (int c = 0; c < 19; c++) drive(c == 0, 1'b0, c == 18);
        chk("abort_fin_mul3", {30'd0, MUL3, done}, 32'd0);
        drive(1'b0, 1'b0, 1'b0);
        chk("abort_fin_idle", {31'd0, busy}, 32'd0);

        // start with abort in IDLE stays IDLE
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        chk("start_abort_idle", {30'd0, busy, MUL1}, 32'd0);

        // start during busy/FIN ignored; start right after FIN accepted
        nd = 0;
        for (int c = 0; c < 40; c++) begin
            drive(c == 0 || c == 5 || c == 18 || c == 19, 1'b0, 1'b0);
            nd += int'(done);
            chk($sformatf("b2b c%0d", c), {30'd0, MUL1, MUL3}, {30'd0, c == 1 || c == 20, c == 18 || c == 37});
        end
        chk("b2b_done_count", 32'(nd), 32'd2);

        // reset mid-ITER
        for (int c = 0; c < 8; c++) drive(c == 0, 1'b0, 1'b0);
        chk("pre_reset_mul2", {31'd0, MUL2}, 32'd1);
        rst_n = 0;
        #1;
        chk("midreset_outs", 32'(outs()), 32'd0);
        chk("midreset_iter", 32'(iter), 32'd0);
        @(posedge clk);
        #1 rst_n = 1;
        nd = 0;
        for (int c = 0; c < 20; c++) begin
            drive(1'b0, 1'b0, 1'b0);
            nd += int'(done) + int'(busy);
        end
        chk("after_reset_quiet", 32'(nd), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
